// File: rtl/n64_vbus_gen_if.sv
// ---------------------------------------------------------------------------
// n64_vbus_gen_if
//   Groups the video-bus generator's pixel handshake and its multiplexed
//   RCP-style video bus.
//
//   px_req  : single-cycle pixel request (generator -> pixel source)
//   px_rgb  : {R[6:0],G[6:0],B[6:0]} supplied while px_req is high
//   nDSYNC  : low during the sync slot of every pixel
//   D       : 7-bit multiplexed bus (sync bits, then R, G, B)
//
//   master : the generator side
//   slave  : the consumer / pixel-source side
// ---------------------------------------------------------------------------
interface n64_vbus_gen_if;
    logic        px_req;
    logic [20:0] px_rgb;
    logic        nDSYNC;
    logic [6:0]  D;

    modport master (
        output px_req,
        output nDSYNC,
        output D,
        input  px_rgb
    );

    modport slave (
        input  px_req,
        input  nDSYNC,
        input  D,
        output px_rgb
    );
endinterface

// File: rtl/n64_vbus_gen.sv
// ---------------------------------------------------------------------------
// n64_vbus_gen
//   Produces an N64 RCP-style multiplexed video bus (nDSYNC + 7-bit D) from
//   pixel data. Every pixel occupies four nCLK cycles: a sync slot carrying
//   {nVSYNC, nCLAMP, nHSYNC, nCSYNC}, then R, G and B. Frame timing is NTSC
//   or PAL, progressive or interlaced; the nVSYNC/nHSYNC edge placement
//   lets downstream line-count / frame-ID logic recover the mode.
//
// Ports
//   nCLK     : video clock, all state changes on its rising edge
//   RST      : synchronous active-high reset, highest priority
//   vmode_i  : 1 = PAL, 0 = NTSC (latched at field start)
//   n480i_i  : 1 = interlaced, 0 = progressive (latched at field start)
//   field_o  : current field, 0 = A, 1 = B (stable for the whole field)
//   vbus     : px_req / px_rgb handshake and nDSYNC / D video bus
//
// The internal counters (slot, h, v) name the slot that is emitted on the
// next rising edge; all bus outputs are registered.
// ---------------------------------------------------------------------------
module n64_vbus_gen #(
    parameter int HS_LEN       = 57,
    parameter int CLAMP_LEN    = 16,
    parameter int VS_LINES     = 3,
    parameter int H_TOTAL_NTSC = 773,
    parameter int H_TOTAL_PAL  = 794,
    parameter int H_ACT_START  = 128,
    parameter int H_ACT        = 640,
    parameter int V_ACT_START  = 16,
    parameter int V_ACT_NTSC   = 240,
    parameter int V_ACT_PAL    = 288,
    // Progressive line counts; interlaced field A is one line shorter.
    parameter int V_TOTAL_NTSC = 263,
    parameter int V_TOTAL_PAL  = 313
) (
    input  logic           nCLK,
    input  logic           RST,
    input  logic           vmode_i,
    input  logic           n480i_i,
    output logic           field_o,
    n64_vbus_gen_if.master vbus
);

    localparam int H_MAX = (H_TOTAL_PAL > H_TOTAL_NTSC) ? H_TOTAL_PAL : H_TOTAL_NTSC;
    localparam int V_MAX = (V_TOTAL_PAL > V_TOTAL_NTSC) ? V_TOTAL_PAL : V_TOTAL_NTSC;
    localparam int H_W   = $clog2(H_MAX);
    localparam int V_W   = $clog2(V_MAX);

    localparam logic [H_W-1:0] HS_END    = H_W'(HS_LEN);
    localparam logic [H_W-1:0] CLAMP_END = H_W'(HS_LEN + CLAMP_LEN);
    localparam logic [H_W-1:0] HACT_BEG  = H_W'(H_ACT_START);
    localparam logic [H_W-1:0] HACT_END  = H_W'(H_ACT_START + H_ACT);
    localparam logic [H_W-1:0] HLAST_N   = H_W'(H_TOTAL_NTSC - 1);
    localparam logic [H_W-1:0] HLAST_P   = H_W'(H_TOTAL_PAL - 1);
    localparam logic [V_W-1:0] VS_END    = V_W'(VS_LINES);
    localparam logic [V_W-1:0] VACT_BEG  = V_W'(V_ACT_START);
    localparam logic [V_W-1:0] VACT_END_N = V_W'(V_ACT_START + V_ACT_NTSC);
    localparam logic [V_W-1:0] VACT_END_P = V_W'(V_ACT_START + V_ACT_PAL);
    localparam logic [V_W-1:0] VLAST_N   = V_W'(V_TOTAL_NTSC - 1);
    localparam logic [V_W-1:0] VLAST_P   = V_W'(V_TOTAL_PAL - 1);

    typedef enum logic [1:0] {
        SLOT_SYNC = 2'd0,
        SLOT_R    = 2'd1,
        SLOT_G    = 2'd2,
        SLOT_B    = 2'd3
    } slot_e;

    // Counter / mode state
    slot_e          slot_q, slot_d;
    logic [H_W-1:0] h_q, h_d;
    logic [V_W-1:0] v_q, v_d;
    logic           field_q, field_d;
    logic           pal_q, pal_d;
    logic           il_q, il_d;
    logic [13:0]    gb_q, gb_d;        // G and B of the pixel being sent

    // Registered outputs
    logic           ndsync_q, ndsync_d;
    logic [6:0]     d_q, d_d;
    logic           px_req_q, px_req_d;
    logic           field_o_q, field_o_d;

    // Decoded view of the slot about to be emitted
    logic           field_start;
    logic           pal_cur, il_cur, field_cur;
    logic [H_W-1:0] h_last;
    logic [V_W-1:0] v_last;
    logic           hsync_n, vsync_n, clamp_n, csync_n;
    logic           vs_low_b;
    logic           active;

    always_comb begin
        // Mode inputs only take effect at the very first slot of a field, so
        // that slot uses the live inputs and every later slot the latch.
        field_start = (slot_q == SLOT_SYNC) && (h_q == '0) && (v_q == '0);
        pal_cur     = field_start ? vmode_i : pal_q;
        il_cur      = field_start ? n480i_i : il_q;
        // A progressive field is always field A, even right after leaving
        // interlaced mode.
        field_cur   = field_start ? (field_q & n480i_i) : field_q;

        h_last = pal_cur ? HLAST_P : HLAST_N;
        v_last = (pal_cur ? VLAST_P : VLAST_N)
                 - {{(V_W-1){1'b0}}, (il_cur & ~field_cur)};

        hsync_n = (h_q >= HS_END);

        // Field B shifts the whole nVSYNC pulse right by HS_LEN pixels so its
        // falling edge does not coincide with an nHSYNC fall.
        vs_low_b = ((v_q != '0) || hsync_n) &&
                   ((v_q < VS_END) || ((v_q == VS_END) && !hsync_n));
        vsync_n  = field_cur ? !vs_low_b : !(v_q < VS_END);

        clamp_n  = !(vsync_n && (h_q >= HS_END) && (h_q < CLAMP_END));
        csync_n  = vsync_n ? hsync_n : !hsync_n;

        active = (h_q >= HACT_BEG) && (h_q < HACT_END) &&
                 (v_q >= VACT_BEG) &&
                 (v_q < (pal_cur ? VACT_END_P : VACT_END_N));
    end

    always_comb begin
        slot_d    = slot_q;
        h_d       = h_q;
        v_d       = v_q;
        field_d   = field_cur;
        pal_d     = pal_cur;
        il_d      = il_cur;
        gb_d      = gb_q;
        ndsync_d  = 1'b1;
        d_d       = 7'h00;
        px_req_d  = 1'b0;
        field_o_d = field_cur;

        unique case (slot_q)
            SLOT_SYNC: begin
                slot_d   = SLOT_R;
                ndsync_d = 1'b0;
                d_d      = {3'b000, vsync_n, clamp_n, hsync_n, csync_n};
                px_req_d = active;
            end
            SLOT_R: begin
                slot_d = SLOT_G;
                // px_req_q is high exactly during the cycle whose end samples
                // px_rgb; inactive pixels send zeros on R, G and B.
                if (px_req_q) begin
                    d_d  = vbus.px_rgb[20:14];
                    gb_d = vbus.px_rgb[13:0];
                end else begin
                    gb_d = '0;
                end
            end
            SLOT_G: begin
                slot_d = SLOT_B;
                d_d    = gb_q[13:7];
            end
            SLOT_B: begin
                slot_d = SLOT_SYNC;
                d_d    = gb_q[6:0];
                if (h_q == h_last) begin
                    h_d = '0;
                    if (v_q == v_last) begin
                        v_d     = '0;
                        field_d = il_cur & ~field_cur;
                    end else begin
                        v_d = v_q + 1'b1;
                    end
                end else begin
                    h_d = h_q + 1'b1;
                end
            end
            default: slot_d = SLOT_SYNC;
        endcase
    end

    always_ff @(posedge nCLK) begin
        if (RST) begin
            slot_q    <= SLOT_SYNC;
            h_q       <= '0;
            v_q       <= '0;
            field_q   <= 1'b0;
            pal_q     <= 1'b0;
            il_q      <= 1'b0;
            gb_q      <= '0;
            ndsync_q  <= 1'b1;
            d_q       <= 7'h00;
            px_req_q  <= 1'b0;
            field_o_q <= 1'b0;
        end else begin
            slot_q    <= slot_d;
            h_q       <= h_d;
            v_q       <= v_d;
            field_q   <= field_d;
            pal_q     <= pal_d;
            il_q      <= il_d;
            gb_q      <= gb_d;
            ndsync_q  <= ndsync_d;
            d_q       <= d_d;
            px_req_q  <= px_req_d;
            field_o_q <= field_o_d;
        end
    end

    assign vbus.nDSYNC = ndsync_q;
    assign vbus.D      = d_q;
    assign vbus.px_req = px_req_q;
    assign field_o     = field_o_q;

endmodule

// File: tb/tb_n64_vbus_gen.sv
// ---------------------------------------------------------------------------
// tb_n64_vbus_gen
//   Two generators run side by side: "full" with the real timing (first
//   lines of an NTSC 240p frame, fixed pixel colour) and "small" with
//   shrunken timing so many whole fields fit (mode changes, interlace,
//   random pixel data, mid-line reset). A frame-position model computes
//   every expected output from the field-relative cycle count.
// ---------------------------------------------------------------------------
module tb_n64_vbus_gen;

    // Index 0 = full timing, index 1 = shrunken timing
    localparam int P_HS [2] = '{57, 5};
    localparam int P_CL [2] = '{16, 3};
    localparam int P_VS [2] = '{3, 3};
    localparam int P_HTN[2] = '{773, 30};
    localparam int P_HTP[2] = '{794, 34};
    localparam int P_HAS[2] = '{128, 9};
    localparam int P_HA [2] = '{640, 16};
    localparam int P_VAS[2] = '{16, 4};
    localparam int P_VAN[2] = '{240, 5};
    localparam int P_VAP[2] = '{288, 6};
    localparam int P_VTN[2] = '{263, 11};
    localparam int P_VTP[2] = '{313, 13};

    logic clk;
    logic rst_f, rst_s;
    logic vmode_f, n480i_f, vmode_s, n480i_s;
    logic field_f, field_s;

    n64_vbus_gen_if bus_f ();
    n64_vbus_gen_if bus_s ();

    n64_vbus_gen dut_full (
        .nCLK    (clk),
        .RST     (rst_f),
        .vmode_i (vmode_f),
        .n480i_i (n480i_f),
        .field_o (field_f),
        .vbus    (bus_f)
    );

    n64_vbus_gen #(
        .HS_LEN(P_HS[1]), .CLAMP_LEN(P_CL[1]), .VS_LINES(P_VS[1]),
        .H_TOTAL_NTSC(P_HTN[1]), .H_TOTAL_PAL(P_HTP[1]),
        .H_ACT_START(P_HAS[1]), .H_ACT(P_HA[1]),
        .V_ACT_START(P_VAS[1]), .V_ACT_NTSC(P_VAN[1]), .V_ACT_PAL(P_VAP[1]),
        .V_TOTAL_NTSC(P_VTN[1]), .V_TOTAL_PAL(P_VTP[1])
    ) dut_small (
        .nCLK    (clk),
        .RST     (rst_s),
        .vmode_i (vmode_s),
        .n480i_i (n480i_s),
        .field_o (field_s),
        .vbus    (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Model state per instance
    int          m_t     [2];   // cycles since the sync slot of pixel 0
    bit          m_rstout[2];
    bit          m_fresh [2];
    bit          m_field [2];
    bit          m_pal   [2];
    bit          m_il    [2];
    logic [20:0] m_cap   [2];

    // Derived-property trackers
    int  last_fall = -1;
    int  n_len_chk = 0;
    bit  p_hs_f    = 1'b1;
    int  req_cnt_f = 0;
    bit  req_done  = 1'b0;
    bit  p_hs_s    = 1'b1;
    bit  p_vs_s    = 1'b1;
    bit  have_vs   = 1'b0;
    bit  res_en    = 1'b0;
    int  hs_rises  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int ht_of(input int i);
        return m_pal[i] ? P_HTP[i] : P_HTN[i];
    endfunction

    function automatic bit m_active(input int i);
        int pix, h, v, vact;
        pix  = m_t[i] / 4;
        h    = pix % ht_of(i);
        v    = pix / ht_of(i);
        vact = m_pal[i] ? P_VAP[i] : P_VAN[i];
        return (h >= P_HAS[i]) && (h < P_HAS[i] + P_HA[i]) &&
               (v >= P_VAS[i]) && (v < P_VAS[i] + vact);
    endfunction

    // Expected {nDSYNC, D, px_req, field_o}
    function automatic logic [9:0] exp_vec(input int i);
        int pix, ph, h, ht;
        bit hs, vs, cl, cs, act;
        logic [6:0] byte_v;
        if (m_rstout[i]) return 10'h200;
        ht  = ht_of(i);
        pix = m_t[i] / 4;
        ph  = m_t[i] % 4;
        h   = pix % ht;
        act = m_active(i);
        hs  = (h >= P_HS[i]);
        if (m_field[i] == 1'b0) vs = !(pix < P_VS[i] * ht);
        else                    vs = !((pix >= P_HS[i]) && (pix < P_VS[i] * ht + P_HS[i]));
        cl  = !(vs && (h >= P_HS[i]) && (h < P_HS[i] + P_CL[i]));
        cs  = vs ? hs : !hs;
        if (ph == 0) return {1'b0, 3'b000, vs, cl, hs, cs, act, m_field[i]};
        if (!act)         byte_v = 7'h00;
        else if (ph == 1) byte_v = m_cap[i][20:14];
        else if (ph == 2) byte_v = m_cap[i][13:7];
        else              byte_v = m_cap[i][6:0];
        return {1'b1, byte_v, 1'b0, m_field[i]};
    endfunction

    // Advance the model across one rising edge, given the inputs seen there.
    task automatic model_adv(input int i, input bit r, input bit vm, input bit il_in,
                             input logic [20:0] rgb);
        int vt;
        if (r) begin
            m_rstout[i] = 1'b1;
            m_fresh[i]  = 1'b1;
            return;
        end
        if (m_fresh[i]) begin
            m_fresh[i]  = 1'b0;
            m_rstout[i] = 1'b0;
            m_t[i]      = 0;
            m_field[i]  = 1'b0;
            m_pal[i]    = vm;
            m_il[i]     = il_in;
            return;
        end
        if ((m_t[i] % 4 == 0) && m_active(i)) m_cap[i] = rgb;
        m_t[i]++;
        vt = m_pal[i] ? P_VTP[i] : P_VTN[i];
        if (m_il[i] && !m_field[i]) vt--;
        if (m_t[i] == 4 * ht_of(i) * vt) begin
            m_t[i]     = 0;
            m_field[i] = il_in & m_il[i] & ~m_field[i];
            m_pal[i]   = vm;
            m_il[i]    = il_in;
        end
    endtask

    task automatic step();
        int pix0, ph0, base;
        bit hs, vs;
        @(posedge clk);
        model_adv(0, rst_f, vmode_f, n480i_f, bus_f.px_rgb);
        model_adv(1, rst_s, vmode_s, n480i_s, bus_s.px_rgb);
        @(negedge clk);
        cyc++;
        check("bus_full",  {22'd0, bus_f.nDSYNC, bus_f.D, bus_f.px_req, field_f}, {22'd0, exp_vec(0)});
        check("bus_small", {22'd0, bus_s.nDSYNC, bus_s.D, bus_s.px_req, field_s}, {22'd0, exp_vec(1)});

        // Full instance: line length, pixel boundaries, requests per line
        if (!m_rstout[0]) begin
            pix0 = m_t[0] / 4;
            ph0  = m_t[0] % 4;
            base = 16 * 773;
            if (bus_f.nDSYNC === 1'b0) begin
                hs = bus_f.D[1];
                if (p_hs_f && !hs) begin
                    if (last_fall >= 0 && n_len_chk < 3) begin
                        check("line_len", cyc - last_fall, 3092);
                        n_len_chk++;
                    end
                    last_fall = cyc;
                end
                p_hs_f = hs;
            end
            if (pix0 == base + 128 && ph0 == 0) check("req_h128", bus_f.px_req, 1);
            if (pix0 == base + 128 && ph0 == 1) check("px_r_h128", bus_f.D, 7'h7F);
            if (pix0 == base + 128 && ph0 == 2) check("px_g_h128", bus_f.D, 7'h00);
            if (pix0 == base + 128 && ph0 == 3) check("px_b_h128", bus_f.D, 7'h55);
            if ((pix0 == base + 127 || pix0 == base + 768) && ph0 == 0)
                check("req_edge", bus_f.px_req, 0);
            if ((pix0 == base + 127 || pix0 == base + 768) && ph0 != 0)
                check("px_edge", bus_f.D, 7'h00);
            if (bus_f.px_req === 1'b1) req_cnt_f++;
            if (!req_done && pix0 / 773 == 17) begin
                check("req_per_line", req_cnt_f, 640);
                req_done = 1'b1;
            end
        end

        // Small instance: nHSYNC rises between nVSYNC rises, modulo 4
        if (m_rstout[1]) begin
            have_vs = 1'b0;
            p_hs_s  = 1'b1;
            p_vs_s  = 1'b1;
        end else if (bus_s.nDSYNC === 1'b0) begin
            hs = bus_s.D[1];
            vs = bus_s.D[3];
            if (!p_vs_s && vs) begin
                if (have_vs && res_en)
                    check("frame_id", (hs_rises % 4) / 2, m_pal[1] ? 0 : 1);
                hs_rises = 0;
                have_vs  = 1'b1;
            end else if (!p_hs_s && hs) begin
                hs_rises++;
            end
            p_hs_s = hs;
            p_vs_s = vs;
        end

        bus_s.px_rgb = 21'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_t[i] = 0; m_rstout[i] = 1'b1; m_fresh[i] = 1'b1;
            m_field[i] = 1'b0; m_pal[i] = 1'b0; m_il[i] = 1'b0; m_cap[i] = '0;
        end
        rst_f = 1'b1; rst_s = 1'b1;
        vmode_f = 1'b0; n480i_f = 1'b0;
        vmode_s = 1'b0; n480i_s = 1'b0;
        bus_f.px_rgb = {7'h7F, 7'h00, 7'h55};
        bus_s.px_rgb = '0;

        repeat (3) step();
        check("reset_full",  {bus_f.nDSYNC, bus_f.D, bus_f.px_req, field_f}, 10'h200);
        check("reset_small", {bus_s.nDSYNC, bus_s.D, bus_s.px_req, field_s}, 10'h200);

        // First slot after release: sync slot of h=0, v=0, field A
        rst_f = 1'b0; rst_s = 1'b0;
        step();
        check("first_full",  {bus_f.nDSYNC, bus_f.D, bus_f.px_req, field_f}, 10'h014);
        check("first_small", {bus_s.nDSYNC, bus_s.D, bus_s.px_req, field_s}, 10'h014);

        // NTSC progressive, three frames
        res_en = 1'b1;
        repeat (3 * 4 * 30 * 11) step();
        check("prog_field", field_s, 0);

        // Switch to PAL interlaced; let it settle, then four fields
        res_en = 1'b0;
        vmode_s = 1'b1; n480i_s = 1'b1;
        repeat (2000) step();
        have_vs = 1'b0;
        res_en  = 1'b1;
        repeat (4 * 1700) step();

        // Mid-field mode toggle
        res_en  = 1'b0;
        vmode_s = 1'b0;
        repeat (3000) step();

        // One-cycle reset while phase 2 is on the bus
        for (int k = 0; k < 8 && !(m_t[1] % 4 == 2); k++) step();
        rst_s = 1'b1;
        step();
        rst_s = 1'b0;
        step();
        check("rst_pulse_first", {bus_s.nDSYNC, bus_s.D, bus_s.px_req, field_s}, 10'h014);

        // Random mode changes
        for (int k = 0; k < 6; k++) begin
            vmode_s = 1'($urandom);
            n480i_s = 1'($urandom);
            repeat ($urandom_range(500, 2500)) step();
        end

        // Let the full-timing instance finish active line 16
        while (!req_done && cyc < 60000) step();
        check("req_line_reached", req_done, 1);
        check("line_len_seen", n_len_chk, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
